// File: rtl/fir_coeff_load_ctrl.sv
// FIR coefficient reload sequencer: decodes toggle-framed software commands, fills the
// inactive ping-pong coefficient bank and swaps banks only on a FIR frame boundary.
module fir_coeff_load_ctrl #(
    parameter int COEFF_W = 18,
    parameter int N_TAPS  = 256,
    parameter int ADDR_W  = 8
) (
    input  logic               OPB_Clk,
    input  logic               OPB_Rst,
    input  logic [31:0]        reg_data,
    input  logic               frame_sync,
    output logic               coeff_we,
    output logic [ADDR_W-1:0]  coeff_addr,
    output logic [COEFF_W-1:0] coeff_data,
    output logic               coeff_wr_bank,
    output logic               active_bank,
    output logic               busy,
    output logic               load_done,
    output logic               err_seq,
    output logic               err_overrun,
    output logic               err_short,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_DATA   = 2'b10;
    localparam logic [1:0] OP_COMMIT = 2'b11;
    localparam logic [ADDR_W:0] TAPS_C = (ADDR_W+1)'(N_TAPS);

    state_t               state_q, state_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 active_q, active_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [COEFF_W-1:0]   data_q, data_d;
    logic                 done_q, done_d;
    logic                 err_seq_q, err_seq_d;
    logic                 err_ovr_q, err_ovr_d;
    logic                 err_short_q, err_short_d;
    logic                 tog_prev_q, tog_prev_d;
    logic                 init_q, init_d;
    logic [2:0]           hdr_q;
    logic [COEFF_W-1:0]   val_q;
    logic                 cmd_valid;
    logic [1:0]           op;
    logic                 unused_reg_bits;

    assign unused_reg_bits = ^reg_data[28:COEFF_W];

    // Register stage is not reset: it must track reg_data through reset so the
    // post-reset init cycle captures the live toggle and never sees a stale edge.
    always_ff @(posedge OPB_Clk) begin
        hdr_q <= reg_data[31:29];
        val_q <= reg_data[COEFF_W-1:0];
    end

    assign op        = hdr_q[1:0];
    assign cmd_valid = !init_q && (hdr_q[2] != tog_prev_q);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        active_d    = active_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_seq_d   = err_seq_q;
        err_ovr_d   = err_ovr_q;
        err_short_d = err_short_q;
        tog_prev_d  = tog_prev_q;
        init_d      = init_q;

        if (init_q) begin
            init_d     = 1'b0;
            tog_prev_d = hdr_q[2];
        end else if (cmd_valid) begin
            tog_prev_d = hdr_q[2];
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (op == OP_START) begin
                        state_d     = ST_LOAD;
                        count_d     = '0;
                        err_seq_d   = 1'b0;
                        err_ovr_d   = 1'b0;
                        err_short_d = 1'b0;
                    end else if (op != OP_NOP) begin
                        err_seq_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (cmd_valid) begin
                    case (op)
                        OP_DATA: begin
                            if (count_q < TAPS_C) begin
                                we_d    = 1'b1;
                                addr_d  = count_q[ADDR_W-1:0];
                                data_d  = val_q;
                                count_d = count_q + 1'b1;
                            end else begin
                                err_ovr_d = 1'b1;
                            end
                        end
                        OP_START: begin
                            count_d     = '0;
                            err_seq_d   = 1'b0;
                            err_ovr_d   = 1'b0;
                            err_short_d = 1'b0;
                        end
                        OP_COMMIT: begin
                            if (count_q == TAPS_C) begin
                                state_d = ST_ARMED;
                            end else begin
                                err_short_d = 1'b1;
                                state_d     = ST_IDLE;
                                count_d     = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_ARMED: begin
                if (cmd_valid && op != OP_NOP) begin
                    err_seq_d = 1'b1;
                end
                if (frame_sync) begin
                    active_d = ~active_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                    count_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            active_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_seq_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_short_q <= 1'b0;
            tog_prev_q  <= 1'b0;
            init_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            active_q    <= active_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_seq_q   <= err_seq_d;
            err_ovr_q   <= err_ovr_d;
            err_short_q <= err_short_d;
            tog_prev_q  <= tog_prev_d;
            init_q      <= init_d;
        end
    end

    assign coeff_we      = we_q;
    assign coeff_addr    = addr_q;
    assign coeff_data    = data_q;
    assign active_bank   = active_q;
    assign coeff_wr_bank = ~active_q;
    assign busy          = (state_q != ST_IDLE);
    assign load_done     = done_q;
    assign err_seq       = err_seq_q;
    assign err_overrun   = err_ovr_q;
    assign err_short     = err_short_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Directed bench for fir_coeff_load_ctrl: expected RAM writes and bank swaps are queued
// at stimulus time and popped by an independent monitor whenever the DUT strobes them.
module tb_fir_coeff_load_ctrl;
    localparam int COEFF_W = 18;
    localparam int N_TAPS  = 256;
    localparam int ADDR_W  = 8;
    localparam int W       = 1 + ADDR_W + COEFF_W;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_DATA   = 2'b10;
    localparam logic [1:0] OP_COMMIT = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;

    logic               clk;
    logic               rst;
    logic [31:0]        reg_data;
    logic               frame_sync;
    logic               coeff_we;
    logic [ADDR_W-1:0]  coeff_addr;
    logic [COEFF_W-1:0] coeff_data;
    logic               coeff_wr_bank;
    logic               active_bank;
    logic               busy;
    logic               load_done;
    logic               err_seq;
    logic               err_overrun;
    logic               err_short;
    logic [1:0]         dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic         swap_q[$];
    logic         tog;

    fir_coeff_load_ctrl #(.COEFF_W(COEFF_W), .N_TAPS(N_TAPS), .ADDR_W(ADDR_W)) dut (
        .OPB_Clk       (clk),
        .OPB_Rst       (rst),
        .reg_data      (reg_data),
        .frame_sync    (frame_sync),
        .coeff_we      (coeff_we),
        .coeff_addr    (coeff_addr),
        .coeff_data    (coeff_data),
        .coeff_wr_bank (coeff_wr_bank),
        .active_bank   (active_bank),
        .busy          (busy),
        .load_done     (load_done),
        .err_seq       (err_seq),
        .err_overrun   (err_overrun),
        .err_short     (err_short),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic cmd(input logic [1:0] op, input logic [17:0] val);
        @(negedge clk);
        tog      = ~tog;
        reg_data = {tog, op, 11'd0, val};
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (coeff_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=bank%0d addr%0h data%0h required=none",
                         coeff_wr_bank, coeff_addr, coeff_data);
            end else begin
                chk("coeff_write", 32'({coeff_wr_bank, coeff_addr, coeff_data}),
                    32'(exp_q.pop_front()));
            end
        end
        if (load_done === 1'b1) begin
            if (swap_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_load_done actual=1 required=0");
            end else begin
                chk("swap_bank", 32'(active_bank), 32'(swap_q.pop_front()));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        tog        = 1'b1;
        frame_sync = 1'b0;
        reg_data   = {1'b1, OP_DATA, 29'd5};

        // 1: stale toggle=1 held through reset must not decode as DATA
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_err_seq", 32'(err_seq), 0);
        chk("t1_we", 32'(coeff_we), 0);
        chk("t1_active", 32'(active_bank), 0);
        chk("t1_state", 32'(dbg_state), 32'(S_IDLE));

        // 2: full load, swap on frame_sync 10 cycles after COMMIT
        cmd(OP_START, 18'd0);
        for (int i = 0; i < N_TAPS; i++) begin
            cmd(OP_DATA, 18'(i));
            exp_q.push_back({1'b1, 8'(i), 18'(i)});
        end
        cmd(OP_COMMIT, 18'd0);
        settle();
        chk("t2_state_armed", 32'(dbg_state), 32'(S_ARMED));
        chk("t2_busy", 32'(busy), 1);
        chk("t2_active_pre", 32'(active_bank), 0);
        chk("t2_err_short", 32'(err_short), 0);
        repeat (8) @(negedge clk);
        swap_q.push_back(1'b1);
        pulse_fs();
        settle();
        chk("t2_active_post", 32'(active_bank), 1);
        chk("t2_state_idle", 32'(dbg_state), 32'(S_IDLE));

        // 3: short load
        do_reset();
        chk("t3_reset_active", 32'(active_bank), 0);
        cmd(OP_START, 18'd0);
        for (int i = 0; i < 100; i++) begin
            cmd(OP_DATA, 18'(i + 256));
            exp_q.push_back({1'b1, 8'(i), 18'(i + 256)});
        end
        cmd(OP_COMMIT, 18'd0);
        settle();
        chk("t3_err_short", 32'(err_short), 1);
        chk("t3_state", 32'(dbg_state), 32'(S_IDLE));
        chk("t3_active", 32'(active_bank), 0);
        chk("t3_err_seq", 32'(err_seq), 0);

        // 4: overrun on 257th DATA, COMMIT still arms
        do_reset();
        cmd(OP_START, 18'd0);
        for (int i = 0; i < N_TAPS; i++) begin
            cmd(OP_DATA, 18'h3FFFF - 18'(i));
            exp_q.push_back({1'b1, 8'(i), 18'h3FFFF - 18'(i)});
        end
        settle();
        chk("t4_no_overrun_yet", 32'(err_overrun), 0);
        cmd(OP_DATA, 18'h01234);
        settle();
        chk("t4_err_overrun", 32'(err_overrun), 1);
        chk("t4_state_load", 32'(dbg_state), 32'(S_LOAD));
        cmd(OP_COMMIT, 18'd0);
        settle();
        chk("t4_state_armed", 32'(dbg_state), 32'(S_ARMED));
        chk("t4_overrun_sticky", 32'(err_overrun), 1);
        swap_q.push_back(1'b1);
        pulse_fs();
        settle();
        chk("t4_active", 32'(active_bank), 1);

        // 5: DATA in IDLE, START clears, restart mid-load
        do_reset();
        cmd(OP_DATA, 18'd7);
        settle();
        chk("t5_err_seq", 32'(err_seq), 1);
        chk("t5_state_idle", 32'(dbg_state), 32'(S_IDLE));
        cmd(OP_START, 18'd0);
        settle();
        chk("t5_err_seq_clr", 32'(err_seq), 0);
        chk("t5_state_load", 32'(dbg_state), 32'(S_LOAD));
        for (int i = 0; i < 50; i++) begin
            cmd(OP_DATA, 18'(i) ^ 18'h2AAAA);
            exp_q.push_back({1'b1, 8'(i), 18'(i) ^ 18'h2AAAA});
        end
        cmd(OP_NOP, 18'd0);
        cmd(OP_START, 18'd0);
        cmd(OP_DATA, 18'h15555);
        exp_q.push_back({1'b1, 8'd0, 18'h15555});
        settle();
        chk("t5_addr_restart", 32'(coeff_addr), 0);
        chk("t5_err_seq_after", 32'(err_seq), 0);

        // 6: frame_sync coincident with COMMIT is ignored; reset while ARMED
        do_reset();
        cmd(OP_START, 18'd0);
        for (int i = 0; i < N_TAPS; i++) begin
            cmd(OP_DATA, 18'(i * 3));
            exp_q.push_back({1'b1, 8'(i), 18'(i * 3)});
        end
        cmd(OP_COMMIT, 18'd0);
        pulse_fs();
        settle();
        chk("t6_no_swap", 32'(active_bank), 0);
        chk("t6_state_armed", 32'(dbg_state), 32'(S_ARMED));
        swap_q.push_back(1'b1);
        pulse_fs();
        settle();
        chk("t6_swap", 32'(active_bank), 1);
        cmd(OP_START, 18'd0);
        for (int i = 0; i < N_TAPS; i++) begin
            cmd(OP_DATA, 18'(i + 1000));
            exp_q.push_back({1'b0, 8'(i), 18'(i + 1000)});
        end
        cmd(OP_COMMIT, 18'd0);
        settle();
        chk("t6_armed2", 32'(dbg_state), 32'(S_ARMED));
        cmd(OP_DATA, 18'd1);
        settle();
        chk("t6_err_seq_armed", 32'(err_seq), 1);
        chk("t6_still_armed", 32'(dbg_state), 32'(S_ARMED));
        @(negedge clk);
        rst = 1'b1;
        settle();
        chk("t6_rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("t6_rst_active", 32'(active_bank), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int n = 0; n < 20 && (exp_q.size() != 0 || swap_q.size() != 0); n++)
            @(negedge clk);
        chk("writes_drained", 32'(exp_q.size()), 0);
        chk("swaps_drained", 32'(swap_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
